// File: rtl/reg_csr_file.sv
// Integer register file plus a minimal machine-mode CSR set (mstatus, mtvec,
// mepc, mcause, mcycle/mcycleh) with trap entry and mret handling.
module reg_csr_file #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRPORT = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRPORT*5-1:0]      rs_addr,
  output logic [NRPORT*XLEN-1:0]   rs_data,
  input  logic                     rd_we,
  input  logic [4:0]               rd_addr,
  input  logic [XLEN-1:0]          rd_wdata,
  input  logic [11:0]              csr_raddr,
  output logic [XLEN-1:0]          csr_rdata,
  output logic                     csr_illegal,
  input  logic                     csr_we,
  input  logic [11:0]              csr_waddr,
  input  logic [XLEN-1:0]          csr_wdata,
  input  logic                     trap,
  input  logic [XLEN-1:0]          trap_pc,
  input  logic [XLEN-1:0]          trap_cause,
  input  logic                     mret,
  output logic [XLEN-1:0]          mtvec_o,
  output logic [XLEN-1:0]          mepc_o,
  output logic                     mie_o
);

  localparam int         AW     = $clog2(NREG);
  localparam logic [5:0] NREG_L = 6'(NREG);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  // ---------------------------------------------------------------- GPRs
  logic [XLEN-1:0] r_gpr [NREG];
  logic            w_gpr_we;

  assign w_gpr_we = rd_we && (rd_addr != 5'd0) && ({1'b0, rd_addr} < NREG_L);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_gpr[i] <= '0;
    end else if (w_gpr_we) begin
      r_gpr[rd_addr[AW-1:0]] <= rd_wdata;
    end
  end

  for (genvar k = 0; k < NRPORT; k++) begin : g_rport
    logic [4:0] w_ra;
    logic       w_valid;
    logic       w_hit;

    assign w_ra    = rs_addr[5*k +: 5];
    assign w_valid = (w_ra != 5'd0) && ({1'b0, w_ra} < NREG_L);
    // Forwarding only ever matches a write that would actually commit.
    assign w_hit   = (BYPASS != 0) && w_gpr_we && (rd_addr == w_ra);
    assign rs_data[XLEN*k +: XLEN] = !w_valid ? '0 :
                                     w_hit    ? rd_wdata :
                                                r_gpr[w_ra[AW-1:0]];
  end

  // ---------------------------------------------------------------- CSRs
  logic            r_mie;
  logic            r_mpie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [63:0]     r_mcycle;

  logic w_wr_mstatus;
  logic w_wr_mtvec;
  logic w_wr_mepc;
  logic w_wr_mcause;
  logic w_wr_mcycle;
  logic w_wr_mcycleh;

  assign w_wr_mstatus = csr_we && (csr_waddr == ADDR_MSTATUS);
  assign w_wr_mtvec   = csr_we && (csr_waddr == ADDR_MTVEC);
  assign w_wr_mepc    = csr_we && (csr_waddr == ADDR_MEPC);
  assign w_wr_mcause  = csr_we && (csr_waddr == ADDR_MCAUSE);
  assign w_wr_mcycle  = csr_we && (csr_waddr == ADDR_MCYCLE);
  assign w_wr_mcycleh = csr_we && (csr_waddr == ADDR_MCYCLEH) && (XLEN == 32);

  // Trap entry beats mret, which beats a software write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
    end else if (trap) begin
      r_mpie <= r_mie;
      r_mie  <= 1'b0;
    end else if (mret) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_wr_mstatus) begin
      r_mie  <= csr_wdata[3];
      r_mpie <= csr_wdata[7];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mepc   <= '0;
      r_mcause <= '0;
    end else if (trap) begin
      r_mepc   <= trap_pc & ALIGN_MASK;
      r_mcause <= trap_cause;
    end else begin
      if (w_wr_mepc)   r_mepc   <= csr_wdata & ALIGN_MASK;
      if (w_wr_mcause) r_mcause <= csr_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtvec <= '0;
    end else if (w_wr_mtvec) begin
      r_mtvec <= csr_wdata & ALIGN_MASK;
    end
  end

  // A write to either half replaces that half and suppresses the increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcycle <= '0;
    end else if (w_wr_mcycleh) begin
      r_mcycle[63:32] <= csr_wdata[31:0];
    end else if (w_wr_mcycle) begin
      if (XLEN == 32) r_mcycle[31:0] <= csr_wdata[31:0];
      else            r_mcycle       <= 64'(csr_wdata);
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end

  always_comb begin
    csr_rdata   = '0;
    csr_illegal = 1'b0;
    case (csr_raddr)
      ADDR_MSTATUS: begin
        csr_rdata[12:11] = 2'b11;
        csr_rdata[7]     = r_mpie;
        csr_rdata[3]     = r_mie;
      end
      ADDR_MTVEC:   csr_rdata = r_mtvec;
      ADDR_MEPC:    csr_rdata = r_mepc;
      ADDR_MCAUSE:  csr_rdata = r_mcause;
      ADDR_MCYCLE:  csr_rdata = r_mcycle[XLEN-1:0];
      ADDR_MCYCLEH: begin
        if (XLEN == 32) csr_rdata   = XLEN'(r_mcycle[63:32]);
        else            csr_illegal = 1'b1;
      end
      default:      csr_illegal = 1'b1;
    endcase
  end

  assign mtvec_o = r_mtvec;
  assign mepc_o  = r_mepc;
  assign mie_o   = r_mie;

endmodule

// File: tb/tb_reg_csr_file.sv
// Directed bench for reg_csr_file: a default instance (NREG=32, BYPASS=1) and a
// reduced one (NREG=16, BYPASS=0) share all inputs.
module tb_reg_csr_file;

  logic        clk;
  logic        rst;
  logic [9:0]  rs_addr;
  logic [63:0] rs_data_a, rs_data_b;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata_a, csr_rdata_b;
  logic        csr_illegal_a, csr_illegal_b;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic        mret;
  logic [31:0] mtvec_a, mtvec_b, mepc_a, mepc_b;
  logic        mie_a, mie_b;

  int n_cmp = 0;
  int n_err = 0;

  reg_csr_file #(.XLEN(32), .NREG(32), .NRPORT(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_a),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata_a), .csr_illegal(csr_illegal_a),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .trap(trap), .trap_pc(trap_pc), .trap_cause(trap_cause), .mret(mret),
    .mtvec_o(mtvec_a), .mepc_o(mepc_a), .mie_o(mie_a)
  );

  reg_csr_file #(.XLEN(32), .NREG(16), .NRPORT(2), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_b),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata_b), .csr_illegal(csr_illegal_b),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .trap(trap), .trap_pc(trap_pc), .trap_cause(trap_cause), .mret(mret),
    .mtvec_o(mtvec_b), .mepc_o(mepc_b), .mie_o(mie_b)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_waddr = a;
    csr_wdata = d;
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic csr_chk(input string nm, input logic [11:0] a, input logic [31:0] e);
    csr_raddr = a;
    #1;
    check(nm, 64'(csr_rdata_a), 64'(e));
    check({nm, "_illegal"}, 64'(csr_illegal_a), 64'd0);
  endtask

  task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause,
                         input logic we, input logic [11:0] wa, input logic [31:0] wd);
    trap       = 1'b1;
    trap_pc    = pc;
    trap_cause = cause;
    csr_we     = we;
    csr_waddr  = wa;
    csr_wdata  = wd;
    tick();
    trap       = 1'b0;
    csr_we     = 1'b0;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ea0;
    logic [31:0] ea1;
    logic [31:0] eb0;
    logic [31:0] eb1;
  } gvec_t;

  gvec_t vec [10];

  initial begin
    // expectations are the same-cycle reads, before the edge that commits the write
    vec[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0};
    vec[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vec[2] = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vec[3] = '{1'b1, 5'd20, 32'h00000055, 5'd0,  5'd20, 32'h0,        32'h00000055, 32'h0,        32'h0};
    vec[4] = '{1'b0, 5'd0,  32'h0,        5'd20, 5'd0,  32'h00000055, 32'h0,        32'h0,        32'h0};
    vec[5] = '{1'b1, 5'd15, 32'h00000F0F, 5'd15, 5'd14, 32'h00000F0F, 32'h0,        32'h0,        32'h0};
    vec[6] = '{1'b0, 5'd0,  32'h0,        5'd15, 5'd31, 32'h00000F0F, 32'h0,        32'h00000F0F, 32'h0};
    vec[7] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd5,  32'hA5A5A5A5, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vec[8] = '{1'b1, 5'd5,  32'h11111111, 5'd5,  5'd31, 32'h11111111, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h0};
    vec[9] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h11111111, 32'hA5A5A5A5, 32'h11111111, 32'h0};

    rst = 1'b0; rs_addr = '0; rd_we = 1'b0; rd_addr = '0; rd_wdata = '0;
    csr_raddr = '0; csr_we = 1'b0; csr_waddr = '0; csr_wdata = '0;
    trap = 1'b0; trap_pc = '0; trap_cause = '0; mret = 1'b0;

    // reset state, before any clock edge
    rs_addr = {5'd31, 5'd5};
    #20;
    check("rst_mtvec", 64'(mtvec_a), 64'd0);
    check("rst_mepc",  64'(mepc_a),  64'd0);
    check("rst_mie",   64'(mie_a),   64'd0);
    check("rst_rs_a",  rs_data_a,    64'd0);
    check("rst_rs_b",  rs_data_b,    64'd0);
    @(negedge clk);
    rst = 1'b1;

    // GPR table
    for (int i = 0; i < 10; i++) begin
      rd_we    = vec[i].we;
      rd_addr  = vec[i].wa;
      rd_wdata = vec[i].wd;
      rs_addr  = {vec[i].ra1, vec[i].ra0};
      #1;
      check($sformatf("gpr%0d_a0", i), 64'(rs_data_a[31:0]),  64'(vec[i].ea0));
      check($sformatf("gpr%0d_a1", i), 64'(rs_data_a[63:32]), 64'(vec[i].ea1));
      check($sformatf("gpr%0d_b0", i), 64'(rs_data_b[31:0]),  64'(vec[i].eb0));
      check($sformatf("gpr%0d_b1", i), 64'(rs_data_b[63:32]), 64'(vec[i].eb1));
      tick();
    end
    rd_we = 1'b0;

    // CSR decode
    csr_chk("mstatus_rst", 12'h300, 32'h00001800);
    csr_raddr = 12'h7C0;
    #1;
    check("ill_rdata", 64'(csr_rdata_a),   64'd0);
    check("ill_flag",  64'(csr_illegal_a), 64'd1);

    // enable, trap, mret
    csr_wr(12'h300, 32'h8);
    csr_chk("mstatus_mie", 12'h300, 32'h00001808);
    check("mie_set", 64'(mie_a), 64'd1);
    do_trap(32'h80000102, 32'hB, 1'b0, 12'h0, 32'h0);
    check("trap_mepc_o", 64'(mepc_a), 64'h80000100);
    csr_chk("trap_mepc",    12'h341, 32'h80000100);
    csr_chk("trap_mcause",  12'h342, 32'h0000000B);
    csr_chk("trap_mstatus", 12'h300, 32'h00001880);
    check("trap_mie", 64'(mie_a), 64'd0);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    csr_chk("mret_mstatus", 12'h300, 32'h00001888);
    check("mret_mie", 64'(mie_a), 64'd1);

    // trap priority against same-cycle software writes
    do_trap(32'h00001237, 32'h2, 1'b1, 12'h341, 32'h40);
    check("prio_mepc", 64'(mepc_a), 64'h1234);
    csr_chk("prio_mstatus1", 12'h300, 32'h00001880);
    do_trap(32'h00002000, 32'h3, 1'b1, 12'h305, 32'h41);
    check("prio_mtvec", 64'(mtvec_a), 64'h40);
    check("prio_mepc2", 64'(mepc_a),  64'h2000);
    do_trap(32'h00003000, 32'h4, 1'b1, 12'h300, 32'h88);
    csr_chk("prio_mstatus2", 12'h300, 32'h00001800);
    do_trap(32'h00003004, 32'h5, 1'b1, 12'h342, 32'h99);
    csr_chk("prio_mcause", 12'h342, 32'h5);
    check("prio_mepc3", 64'(mepc_a), 64'h3004);
    mret = 1'b1; csr_we = 1'b1; csr_waddr = 12'h300; csr_wdata = 32'h8;
    tick();
    mret = 1'b0; csr_we = 1'b0;
    csr_chk("mret_vs_we", 12'h300, 32'h00001880);

    // write masking
    csr_wr(12'h305, 32'h00000103);
    csr_chk("mtvec_mask", 12'h305, 32'h00000100);
    csr_wr(12'h341, 32'hFFFFFFFF);
    check("mepc_mask", 64'(mepc_a), 64'hFFFFFFFC);
    csr_wr(12'h342, 32'h8000000B);
    csr_chk("mcause_wr", 12'h342, 32'h8000000B);
    csr_wr(12'h300, 32'hFFFFFFFF);
    csr_chk("mstatus_mask", 12'h300, 32'h00001888);

    // mcycle carry and half writes
    csr_wr(12'hB80, 32'h0);
    csr_wr(12'hB00, 32'hFFFFFFFF);
    csr_chk("cyc_pre_lo", 12'hB00, 32'hFFFFFFFF);
    csr_chk("cyc_pre_hi", 12'hB80, 32'h0);
    tick();
    csr_chk("cyc_wrap_lo", 12'hB00, 32'h0);
    csr_chk("cyc_wrap_hi", 12'hB80, 32'h1);
    tick();
    csr_chk("cyc_inc_lo", 12'hB00, 32'h1);
    csr_wr(12'hB00, 32'h5);
    csr_chk("cyc_wlo_lo", 12'hB00, 32'h5);
    csr_chk("cyc_wlo_hi", 12'hB80, 32'h1);
    tick();
    csr_chk("cyc_inc2_lo", 12'hB00, 32'h6);
    csr_wr(12'hB80, 32'h7);
    csr_chk("cyc_whi_lo", 12'hB00, 32'h6);
    csr_chk("cyc_whi_hi", 12'hB80, 32'h7);

    // asynchronous reset mid-run with writes pending
    rd_we = 1'b1; rd_addr = 5'd7; rd_wdata = 32'h77;
    csr_we = 1'b1; csr_waddr = 12'h305; csr_wdata = 32'h300;
    rs_addr = {5'd31, 5'd5};
    #10;
    rst = 1'b0;
    #1;
    check("arst_mtvec", 64'(mtvec_a), 64'd0);
    check("arst_mepc",  64'(mepc_a),  64'd0);
    check("arst_mie",   64'(mie_a),   64'd0);
    check("arst_rs_a",  rs_data_a,    64'd0);
    check("arst_rs_b",  rs_data_b,    64'd0);
    csr_chk("arst_mcause",  12'h342, 32'h0);
    csr_chk("arst_mstatus", 12'h300, 32'h00001800);
    csr_chk("arst_cyc_lo",  12'hB00, 32'h0);
    csr_chk("arst_cyc_hi",  12'hB80, 32'h0);
    tick();
    rd_we = 1'b0; csr_we = 1'b0;
    rs_addr = {5'd5, 5'd7};
    #1;
    check("arst_edge_x7",    64'(rs_data_a[31:0]), 64'd0);
    check("arst_edge_mtvec", 64'(mtvec_a),         64'd0);
    csr_chk("arst_edge_cyc", 12'hB00, 32'h0);
    rst = 1'b1;
    csr_chk("rel_cyc0", 12'hB00, 32'h0);
    tick();
    csr_chk("rel_cyc1", 12'hB00, 32'h1);
    csr_chk("rel_cych", 12'hB80, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_csr_file.md
REG_CSR_FILE -- requirements
Module: reg_csr_file

Interface
REQ-001 The block SHALL be parametrised as follows, one per line: name, default, meaning.
- XLEN, 32, data width of GPRs and CSRs (32 or 64).
- NREG, 32, implemented GPR count (16 for RV32E or 32).
- NRPORT, 2, number of GPR read ports (1-4).
- BYPASS, 1, when 1, write data is forwarded to same-cycle reads.
REQ-002 The ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, reset, asynchronous, active-low.
- rs_addr, in, NRPORT*5, packed GPR read addresses; port k uses bits [5k+4:5k].
- rs_data, out, NRPORT*XLEN, packed GPR read data.
- rd_we, in, 1, GPR write enable.
- rd_addr, in, 5, GPR write address.
- rd_wdata, in, XLEN, GPR write data.
- csr_raddr, in, 12, CSR read address.
- csr_rdata, out, XLEN, CSR read data.
- csr_illegal, out, 1, csr_raddr is not implemented.
- csr_we, in, 1, CSR write enable.
- csr_waddr, in, 12, CSR write address.
- csr_wdata, in, XLEN, CSR write data.
- trap, in, 1, trap-entry strobe.
- trap_pc, in, XLEN, PC of the trapping instruction.
- trap_cause, in, XLEN, cause code for the trap.
- mret, in, 1, trap-return strobe.
- mtvec_o, out, XLEN, current mtvec.
- mepc_o, out, XLEN, current mepc.
- mie_o, out, 1, current mstatus.MIE.

Function
REQ-003 GPR reads SHALL be combinational; x0 and any address >= NREG SHALL read as zero.
REQ-004 A GPR write SHALL occur on the rising edge when rd_we=1, rd_addr!=0 and rd_addr<NREG; all other writes are ignored.
REQ-005 With BYPASS=1, a read port whose address equals a same-cycle valid write address SHALL return rd_wdata; with BYPASS=0 it returns the old value.
REQ-006 The implemented CSRs SHALL be mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mcycle 0xB00, and mcycleh 0xB80 (mcycleh only when XLEN=32).
REQ-007 CSR reads SHALL be combinational; an unimplemented csr_raddr SHALL give csr_rdata=0 and csr_illegal=1, otherwise csr_illegal=0.
REQ-008 Only mstatus bits MIE[3], MPIE[7] and MPP[12:11] SHALL be stored; MPP SHALL always read 2'b11 and all other bits read 0.
REQ-009 mtvec[1:0] and mepc[1:0] SHALL be forced to 0 on write.
REQ-010 mcycle SHALL be a 64-bit counter that increments by 1 every cycle out of reset and wraps from all-ones to 0.
REQ-011 A CSR write to mcycle or mcycleh SHALL replace that half in place of the increment that cycle, leaving the other half unchanged.
REQ-012 On trap=1, the edge SHALL load mepc<=trap_pc (with [1:0] cleared), mcause<=trap_cause, MPIE<=MIE and MIE<=0.
REQ-013 On mret=1 without trap, the edge SHALL load MIE<=MPIE and MPIE<=1.
REQ-014 Update priority per CSR SHALL be trap > mret > csr_we: a csr_we to mepc, mcause or mstatus in the same cycle as trap is discarded, while csr_we to other CSRs proceeds.
REQ-015 CSR writes to unimplemented addresses SHALL be ignored.
REQ-016 CSR reads SHALL not forward same-cycle CSR writes; outputs reflect registered state.
REQ-017 mtvec_o, mepc_o and mie_o SHALL be driven directly from the registers with no added latency.

Reset
REQ-018 While rst=0, all GPRs, mtvec, mepc, mcause, MIE, MPIE and mcycle SHALL be 0 immediately, independent of clk.
REQ-019 Reset asserted mid-operation SHALL discard any pending or same-edge write.
REQ-020 The first increment of mcycle SHALL occur on the first rising edge after rst rises.

Verification
REQ-021 The bench SHALL cover: write x5=0xDEADBEEF and read on both ports the same cycle -> with BYPASS=1 both ports return 0xDEADBEEF that cycle; with BYPASS=0 they return 0 that cycle and 0xDEADBEEF the next.
REQ-022 The bench SHALL cover: write x0=0x1234 and, with NREG=16, write x20=0x55 -> reads of x0 and x20 return 0.
REQ-023 The bench SHALL cover: set MIE=1 via csr 0x300=0x8, then trap with pc=0x80000102 and cause=0xB -> mepc=0x80000100, mcause=0xB, mstatus reads 0x1880, and mie_o=0.
REQ-024 The bench SHALL cover: mret on the cycle after REQ-023's trap -> mstatus reads 0x1888 and mie_o=1.
REQ-025 The bench SHALL cover: trap and csr_we to mepc=0x40 and to mtvec=0x41 in the same cycle -> mepc takes trap_pc and mtvec=0x40.
REQ-026 The bench SHALL cover: preload mcycle=0xFFFFFFFF (XLEN=32) and run 1 cycle -> mcycle=0 and mcycleh=1; read of 0x7C0 -> csr_rdata=0 and csr_illegal=1; rst=0 mid-run -> all state is 0 without a clock edge.
